lc3_mem_unit: RTL
=================

// Module: lc3_mem_unit
// PURPOSE
//  MAR/MDR register pair plus word-addressed memory for the LC-3 datapath, directly downstream of the control FSM.
//  Consumes the FSM's ldMAR/ldMDR/selMDR/memWE/enaMDR and special preload strobes.
//  Performs multi-cycle reads and writes; returns a one-cycle mem_ready (LC-3 "R") so the FSM can hold state 33 until data lands.
// PARAMETERS
//  ADDR_W       8   memory address bits; depth = 2**ADDR_W words of 16 bits; MAR[ADDR_W-1:0] used
//  MEM_LATENCY  2   edges from accepted request to completion; legal range 1..15
// PORTS
//  clk          in   1   single clock, all state updates on posedge
//  reset        in   1   synchronous, active-high
//  bus_in       in   16  shared datapath bus (value being driven by PC/ALU/MARMUX)
//  ldMAR        in   1   load MAR
//  ldMARSpcIn   in   1   with ldMAR: MAR <= MARSpcIn instead of bus_in
//  MARSpcIn     in   16  preload address
//  ldMDR        in   1   load MDR, source per selMDR
//  selMDR       in   2   00 bus_in, 01 memory read, 11 MDRSpcIn, 10 reserved (no load)
//  MDRSpcIn     in   16  preload data
//  memWE        in   1   request write mem[MAR] <= MDR
//  enaMDR       in   1   request to drive MDR onto bus
//  mdr_out      out  16  current MDR contents
//  mdr_drive    out  1   = enaMDR; top level gates tri-state from this
//  mar_out      out  16  current MAR contents
//  busy         out  1   high while an access is in flight
//  mem_ready    out  1   one-cycle pulse on access completion
// BEHAVIOUR
//  Reset: MAR=0, MDR=0, busy=0, mem_ready=0, state IDLE, counter 0; memory contents untouched.
//  States: IDLE, RD, WR. Counter cnt loaded with MEM_LATENCY-1 on entry to RD/WR.
//  IDLE, edge E0:
//  - memWE=1 -> WR; captures nothing extra, MAR/MDR frozen.
//  - else ldMDR=1 & selMDR=01 -> RD.
//  - memWE wins over simultaneous read request; read is dropped, not queued.
//  - ldMAR / ldMDR with selMDR 00/11 take effect at E0 in IDLE only.
//  - Same-edge ldMAR with access start: access uses the OLD MAR; the new MAR is loaded.
//  RD/WR: cnt decrements each edge; at the edge where cnt==0 (edge E0+MEM_LATENCY):
//  - RD commits MDR <= mem[MAR[ADDR_W-1:0]]; WR commits mem[...] <= MDR.
//  - return to IDLE.
//  mem_ready=1 for exactly the cycle after completion edge; busy=1 from E0 to completion edge.
//  A new request is accepted at the edge following completion (back-to-back throughput MEM_LATENCY+1 edges).
//  While busy: ldMAR, ldMDR, memWE ignored (no side effects, no queuing); MAR and MDR hold.
//  Address wrap: MAR bits above ADDR_W ignored, e.g. ADDR_W=8, MAR=16'h3001 -> word 8'h01.
//  Reset mid-access: access aborted, no memory write, mem_ready stays 0.
//  selMDR=10 with ldMDR: MDR holds, no access started.
// STRUCTURE
//  lc3_pkg: selMDR encodings (MDR_SEL_BUS/MEM/SPC), state enum (MEM_IDLE/RD/WR).
//  Sub-module lc3_mem_array: 16-bit x 2**ADDR_W RAM, one write port, one combinational read port; no reset.
//  lc3_mem_unit holds MAR, MDR, FSM, counter, output logic.
// TESTING
//  1 Reset then idle: outputs all 0, busy=0, mem_ready=0 for 10 cycles.
//  2 Preload: ldMAR+ldMARSpcIn MARSpcIn=16'h3001.
//    Then ldMDR selMDR=11 MDRSpcIn=16'hE207.
//    Then memWE -> mem_ready 2 edges later; readback via selMDR=01 gives mdr_out=16'hE207.
//  3 memWE and ldMDR/selMDR=01 same edge: write performed, MDR unchanged, single mem_ready pulse.
//  4 ldMAR bus_in=16'h0042 during RD busy: MAR stays old value; completed read uses old address.
//  5 reset asserted one edge into WR: target word keeps prior contents, mem_ready never pulses.
//  6 MEM_LATENCY=1 and 15: read completes exactly 1/15 edges after request; wrap check MAR=16'hFF05 hits word 05.

Source files
------------

// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lc3_pkg
// Brief   : Shared encodings for the LC-3 MAR/MDR memory unit.
// Revision: 1.0 - initial release
// ============================================================================
package lc3_pkg;

  typedef logic [15:0] word_t;

  // selMDR source encodings (2'b10 is reserved and loads nothing)
  localparam logic [1:0] MDR_SEL_BUS = 2'b00;
  localparam logic [1:0] MDR_SEL_MEM = 2'b01;
  localparam logic [1:0] MDR_SEL_RSV = 2'b10;
  localparam logic [1:0] MDR_SEL_SPC = 2'b11;

  // Access FSM states
  localparam logic [1:0] MEM_IDLE = 2'd0;
  localparam logic [1:0] MEM_RD   = 2'd1;
  localparam logic [1:0] MEM_WR   = 2'd2;

  function automatic logic is_mem_read(input logic ld, input logic [1:0] sel);
    return ld && (sel == MDR_SEL_MEM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_mem_array.sv
`default_nettype none
// ============================================================================
// Module  : lc3_mem_array
// Brief   : 16-bit x 2**ADDR_W RAM, one write port, combinational read, no reset.
// Revision: 1.0 - initial release
// ============================================================================
module lc3_mem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  localparam int C_DEPTH = 2 ** ADDR_W;

  logic [15:0] r_mem [C_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/lc3_mem_unit.sv
`default_nettype none
// ============================================================================
// Module  : lc3_mem_unit
// Brief   : MAR/MDR pair with a fixed-latency multi-cycle memory access FSM.
// Revision: 1.0 - initial release
// ============================================================================
module lc3_mem_unit
  import lc3_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_in,
  input  logic        ldMAR,
  input  logic        ldMARSpcIn,
  input  logic [15:0] MARSpcIn,
  input  logic        ldMDR,
  input  logic [1:0]  selMDR,
  input  logic [15:0] MDRSpcIn,
  input  logic        memWE,
  input  logic        enaMDR,
  output logic [15:0] mdr_out,
  output logic        mdr_drive,
  output logic [15:0] mar_out,
  output logic        busy,
  output logic        mem_ready
);

  localparam logic [3:0] C_CNT_INIT = 4'(MEM_LATENCY - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  word_t             r_mar;
  word_t             r_mdr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_mem_ready;

  logic  w_idle;
  logic  w_start_wr;
  logic  w_start_rd;
  logic  w_done;
  logic  w_mem_we;
  word_t w_rdata;

  assign w_idle     = (r_state == MEM_IDLE);
  assign w_start_wr = w_idle && memWE;
  assign w_start_rd = w_idle && !memWE && is_mem_read(ldMDR, selMDR);
  assign w_done     = !w_idle && (r_cnt == 4'd0);
  // Reset on the completion edge must still suppress the write.
  assign w_mem_we   = (r_state == MEM_WR) && w_done && !reset;

  lc3_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_mem_we),
    .addr  (r_addr),
    .wdata (r_mdr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= MEM_IDLE;
      r_cnt       <= 4'd0;
      r_mar       <= 16'h0000;
      r_mdr       <= 16'h0000;
      r_addr      <= '0;
      r_mem_ready <= 1'b0;
    end else begin
      r_mem_ready <= w_done;
      if (w_idle) begin
        if (ldMAR) begin
          r_mar <= ldMARSpcIn ? MARSpcIn : bus_in;
        end
        // A write start freezes MDR; it is the data being stored.
        if (!memWE && ldMDR) begin
          case (selMDR)
            MDR_SEL_BUS: r_mdr <= bus_in;
            MDR_SEL_SPC: r_mdr <= MDRSpcIn;
            default:     r_mdr <= r_mdr;
          endcase
        end
        // Address is latched here so a same-edge MAR load does not retarget the access.
        if (w_start_wr || w_start_rd) begin
          r_addr  <= r_mar[ADDR_W-1:0];
          r_cnt   <= C_CNT_INIT;
          r_state <= w_start_wr ? MEM_WR : MEM_RD;
        end
      end else if (w_done) begin
        if (r_state == MEM_RD) begin
          r_mdr <= w_rdata;
        end
        r_state <= MEM_IDLE;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign mdr_out   = r_mdr;
  assign mdr_drive = enaMDR;
  assign mar_out   = r_mar;
  assign busy      = !w_idle;
  assign mem_ready = r_mem_ready;

endmodule
`default_nettype wire
